// File: rtl/ulpi_pkg.sv
// rtl/ulpi_pkg.sv - ULPI register engine types, TX CMD constants and command helper (ULPI_EXT_REG_EN widens addresses)
package ulpi_pkg;

  typedef enum logic [3:0] {
    S_PHYRST,
    S_IDLE,
    S_TXCMD,
    S_EXTADDR,
    S_WDATA,
    S_STP,
    S_RD_TA1,
    S_RD_DATA,
    S_RD_TA2
  } ulpi_state_t;

  localparam logic [1:0] REGW     = 2'b10;
  localparam logic [1:0] REGR     = 2'b11;
  localparam logic [5:0] EXT_ADDR = 6'h2F;
  localparam logic [7:0] IDLE_CMD = 8'h00;

`ifdef ULPI_EXT_REG_EN
  localparam int ADDR_W = 8;
`else
  localparam int ADDR_W = 6;
`endif

  // Addresses beyond the immediate range are redirected to the extended-address escape.
  function automatic logic [7:0] tx_cmd(input logic we, input logic [ADDR_W-1:0] addr);
    logic [5:0] a;
`ifdef ULPI_EXT_REG_EN
    a = (addr > 8'h3F) ? EXT_ADDR : addr[5:0];
`else
    a = addr;
`endif
    return {(we ? REGW : REGR), a};
  endfunction

endpackage

// File: rtl/ulpi_reg_ctrl.sv
// rtl/ulpi_reg_ctrl.sv - ULPI link register read/write engine, RX CMD capture and PHY reset sequencing
// ULPI_EXT_REG_EN enables 8-bit register addresses through the EXTADDR phase.
module ulpi_reg_ctrl
  import ulpi_pkg::*;
#(
  parameter int RST_CYCLES = 600,
  parameter int CNT_W      = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic              o_ack,
  output logic [7:0]        o_rdata,
  output logic              o_busy,
  output logic [7:0]        o_rxcmd,
  output logic              o_rxcmd_valid,
  input  logic [7:0]        i_ulpi_data,
  output logic [7:0]        o_ulpi_data,
  input  logic              i_ulpi_dir,
  input  logic              i_ulpi_nxt,
  output logic              o_ulpi_stp,
  output logic              o_ulpi_rst_n
);

  ulpi_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              dir_q;
  logic              pend;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= S_PHYRST;
      cnt           <= '0;
      dir_q         <= 1'b0;
      pend          <= 1'b0;
      req_we        <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= 8'h00;
      o_ack         <= 1'b0;
      o_rdata       <= 8'h00;
      o_busy        <= 1'b1;
      o_rxcmd       <= 8'h00;
      o_rxcmd_valid <= 1'b0;
      o_ulpi_data   <= IDLE_CMD;
      o_ulpi_stp    <= 1'b0;
      o_ulpi_rst_n  <= 1'b0;
    end else begin
      dir_q         <= i_ulpi_dir;
      o_ack         <= 1'b0;
      o_ulpi_stp    <= 1'b0;
      o_rxcmd_valid <= 1'b0;

      // First dir=1 cycle is bus turnaround; read data phases belong to the register read.
      if (i_ulpi_dir && dir_q && !i_ulpi_nxt && state != S_RD_TA1 && state != S_RD_DATA) begin
        o_rxcmd       <= i_ulpi_data;
        o_rxcmd_valid <= 1'b1;
      end

      case (state)
        S_PHYRST: begin
          if (!o_ulpi_rst_n) begin
            if (cnt == CNT_W'(RST_CYCLES - 1)) o_ulpi_rst_n <= 1'b1;
            else                               cnt <= cnt + 1'b1;
          end else begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end
        S_IDLE: begin
          o_ulpi_data <= IDLE_CMD;
          if (pend) begin
            if (!i_ulpi_dir) begin
              pend        <= 1'b0;
              o_ulpi_data <= tx_cmd(req_we, req_addr);
              state       <= S_TXCMD;
            end
          end else if (i_req && !o_busy) begin
            req_we    <= i_we;
            req_addr  <= i_addr;
            req_wdata <= i_wdata;
            o_busy    <= 1'b1;
            if (i_ulpi_dir) begin
              pend <= 1'b1;
            end else begin
              o_ulpi_data <= tx_cmd(i_we, i_addr);
              state       <= S_TXCMD;
            end
          end
        end
        S_TXCMD: begin
          if (i_ulpi_dir) begin
            o_ulpi_data <= IDLE_CMD;
            pend        <= 1'b1;
            state       <= S_IDLE;
          end else if (i_ulpi_nxt) begin
`ifdef ULPI_EXT_REG_EN
            if (req_addr > 8'h3F) begin
              o_ulpi_data <= req_addr;
              state       <= S_EXTADDR;
            end else
`endif
            if (req_we) begin
              o_ulpi_data <= req_wdata;
              state       <= S_WDATA;
            end else begin
              o_ulpi_data <= IDLE_CMD;
              state       <= S_RD_TA1;
            end
          end
        end
`ifdef ULPI_EXT_REG_EN
        S_EXTADDR: begin
          if (i_ulpi_dir) begin
            o_ulpi_data <= IDLE_CMD;
            pend        <= 1'b1;
            state       <= S_IDLE;
          end else if (i_ulpi_nxt) begin
            if (req_we) begin
              o_ulpi_data <= req_wdata;
              state       <= S_WDATA;
            end else begin
              o_ulpi_data <= IDLE_CMD;
              state       <= S_RD_TA1;
            end
          end
        end
`endif
        S_WDATA: begin
          if (i_ulpi_dir) begin
            o_ulpi_data <= IDLE_CMD;
            pend        <= 1'b1;
            state       <= S_IDLE;
          end else if (i_ulpi_nxt) begin
            o_ulpi_data <= IDLE_CMD;
            o_ulpi_stp  <= 1'b1;
            state       <= S_STP;
          end
        end
        S_STP: begin
          o_ack  <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        S_RD_TA1: begin
          if (i_ulpi_dir) state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          o_rdata <= i_ulpi_data;
          state   <= S_RD_TA2;
        end
        S_RD_TA2: begin
          if (!i_ulpi_dir) begin
            o_ack  <= 1'b1;
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_PHYRST;
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// tb/tb_ulpi_reg_ctrl.sv - directed bench for ulpi_reg_ctrl: reset, write, read, abort, RX CMD, busy, address modes
module tb_ulpi_reg_ctrl;
  import ulpi_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [7:0]        wdata = 8'h00;
  logic              ack;
  logic [7:0]        rdata;
  logic              busy;
  logic [7:0]        rxcmd;
  logic              rxcmd_valid;
  logic [7:0]        phy_data = 8'h00;
  logic [7:0]        link_data;
  logic              dir = 1'b0;
  logic              nxt = 1'b0;
  logic              stp;
  logic              phy_rst_n;

  int total = 0;
  int bad = 0;

  ulpi_reg_ctrl dut (
    .i_clk(clk), .i_rst(rst_n), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_ack(ack), .o_rdata(rdata), .o_busy(busy), .o_rxcmd(rxcmd), .o_rxcmd_valid(rxcmd_valid),
    .i_ulpi_data(phy_data), .o_ulpi_data(link_data), .i_ulpi_dir(dir), .i_ulpi_nxt(nxt),
    .o_ulpi_stp(stp), .o_ulpi_rst_n(phy_rst_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phy_reset(input string tag);
    int n = 0;
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick();
      n++;
      if (phy_rst_n) done = 1;
    end
    total++; if (n !== 600 || !done) begin bad++; $display("FAIL %s_rst_len got=%0d exp=600", tag, n); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_at_release got=%b exp=1", tag, busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_fall got=%b exp=0", tag, busy); end
    total++; if (link_data !== 8'h00) begin bad++; $display("FAIL %s_idle_data got=%h exp=00", tag, link_data); end
  endtask

  task automatic test_reset();
    tick(); tick(); tick();
    total++; if (phy_rst_n !== 1'b0) begin bad++; $display("FAIL rst_phy_rst_n got=%b exp=0", phy_rst_n); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", busy); end
    total++; if (link_data !== 8'h00 || stp !== 1'b0) begin bad++; $display("FAIL rst_bus got=%h/%b exp=00/0", link_data, stp); end
    total++; if (ack !== 1'b0 || rdata !== 8'h00) begin bad++; $display("FAIL rst_ack_rdata got=%b/%h exp=0/00", ack, rdata); end
    total++; if (rxcmd !== 8'h00 || rxcmd_valid !== 1'b0) begin bad++; $display("FAIL rst_rxcmd got=%h/%b exp=00/0", rxcmd, rxcmd_valid); end
    rst_n = 1'b1;
    wait_phy_reset("reset");
  endtask

  task automatic test_write();
    req = 1; we = 1; addr = 'h04; wdata = 8'h45;
    tick(); req = 0;
    total++; if (link_data !== 8'h84 || busy !== 1'b1) begin bad++; $display("FAIL wr_txcmd got=%h/%b exp=84/1", link_data, busy); end
    tick(); nxt = 1;
    total++; if (link_data !== 8'h84) begin bad++; $display("FAIL wr_txcmd_hold got=%h exp=84", link_data); end
    tick();
    total++; if (link_data !== 8'h45 || stp !== 1'b0) begin bad++; $display("FAIL wr_data got=%h/%b exp=45/0", link_data, stp); end
    tick(); nxt = 0;
    total++; if (stp !== 1'b1 || link_data !== 8'h00 || ack !== 1'b0) begin bad++; $display("FAIL wr_stp got=%b/%h/%b exp=1/00/0", stp, link_data, ack); end
    tick();
    total++; if (ack !== 1'b1 || busy !== 1'b0 || stp !== 1'b0) begin bad++; $display("FAIL wr_ack got=%b/%b/%b exp=1/0/0", ack, busy, stp); end
    tick();
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL wr_ack_pulse got=%b exp=0", ack); end
  endtask

  task automatic test_read();
    req = 1; we = 0; addr = 'h00;
    tick(); req = 0;
    total++; if (link_data !== 8'hC0) begin bad++; $display("FAIL rd_txcmd got=%h exp=c0", link_data); end
    tick(); nxt = 1;
    tick(); nxt = 0; dir = 1; phy_data = 8'hFF;
    total++; if (link_data !== 8'h00) begin bad++; $display("FAIL rd_release_bus got=%h exp=00", link_data); end
    tick(); phy_data = 8'h24;
    total++; if (ack !== 1'b0 || rxcmd_valid !== 1'b0) begin bad++; $display("FAIL rd_ta got=%b/%b exp=0/0", ack, rxcmd_valid); end
    tick(); dir = 0; phy_data = 8'h00;
    total++; if (ack !== 1'b0 || rxcmd_valid !== 1'b0) begin bad++; $display("FAIL rd_data_cycle got=%b/%b exp=0/0", ack, rxcmd_valid); end
    tick();
    total++; if (ack !== 1'b1 || rdata !== 8'h24 || busy !== 1'b0) begin bad++; $display("FAIL rd_ack got=%b/%h/%b exp=1/24/0", ack, rdata, busy); end
    total++; if (rxcmd_valid !== 1'b0 || rxcmd !== 8'h00) begin bad++; $display("FAIL rd_no_rxcmd got=%b/%h exp=0/00", rxcmd_valid, rxcmd); end
    tick();
    total++; if (rdata !== 8'h24 || ack !== 1'b0) begin bad++; $display("FAIL rd_hold got=%h/%b exp=24/0", rdata, ack); end
  endtask

  task automatic test_abort();
    int acks = 0;
    req = 1; we = 1; addr = 'h0A; wdata = 8'h33;
    tick(); req = 0; dir = 1; phy_data = 8'h00;
    total++; if (link_data !== 8'h8A) begin bad++; $display("FAIL ab_txcmd got=%h exp=8a", link_data); end
    tick(); phy_data = 8'h4C;
    total++; if (link_data !== 8'h00 || stp !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL ab_drop got=%h/%b/%b exp=00/0/1", link_data, stp, busy); end
    tick(); dir = 0; phy_data = 8'h00;
    total++; if (rxcmd_valid !== 1'b1 || rxcmd !== 8'h4C) begin bad++; $display("FAIL ab_rxcmd got=%b/%h exp=1/4c", rxcmd_valid, rxcmd); end
    tick();
    total++; if (link_data !== 8'h8A || rxcmd_valid !== 1'b0) begin bad++; $display("FAIL ab_reissue got=%h/%b exp=8a/0", link_data, rxcmd_valid); end
    for (int i = 0; i < 8; i++) begin
      if (i == 0) nxt = 1;
      if (i == 3) nxt = 0;
      if (i == 1) begin
        total++; if (link_data !== 8'h33) begin bad++; $display("FAIL ab_wdata got=%h exp=33", link_data); end
      end
      tick();
      if (ack) acks++;
    end
    total++; if (acks !== 1) begin bad++; $display("FAIL ab_ack_count got=%0d exp=1", acks); end
  endtask

  task automatic test_rxcmd_burst();
    int pulses = 0;
    dir = 1; phy_data = 8'h11;
    tick(); phy_data = 8'h21; if (rxcmd_valid) pulses++;
    tick(); phy_data = 8'h22; if (rxcmd_valid) pulses++;
    total++; if (rxcmd !== 8'h21) begin bad++; $display("FAIL rx_first got=%h exp=21", rxcmd); end
    tick(); phy_data = 8'h23; if (rxcmd_valid) pulses++;
    tick(); dir = 0; phy_data = 8'h00; if (rxcmd_valid) pulses++;
    total++; if (rxcmd !== 8'h23) begin bad++; $display("FAIL rx_last got=%h exp=23", rxcmd); end
    tick(); if (rxcmd_valid) pulses++;
    total++; if (pulses !== 3) begin bad++; $display("FAIL rx_pulses got=%0d exp=3", pulses); end
    dir = 1; phy_data = 8'h00;
    tick(); phy_data = 8'h99; nxt = 1;
    tick(); dir = 0; nxt = 0; phy_data = 8'h00;
    total++; if (rxcmd_valid !== 1'b0 || rxcmd !== 8'h23) begin bad++; $display("FAIL rx_pkt_ignored got=%b/%h exp=0/23", rxcmd_valid, rxcmd); end
    tick();
  endtask

  task automatic test_busy_ignore();
    req = 1; we = 1; addr = 'h01; wdata = 8'h5A;
    tick(); we = 0; addr = 'h3F;
    tick(); nxt = 1;
    total++; if (link_data !== 8'h81) begin bad++; $display("FAIL busy_cmd_kept got=%h exp=81", link_data); end
    tick();
    tick(); req = 0; nxt = 0;
    tick();
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL busy_ack got=%b exp=1", ack); end
    tick();
    total++; if (busy !== 1'b0 || link_data !== 8'h00) begin bad++; $display("FAIL busy_not_queued got=%b/%h exp=0/00", busy, link_data); end
  endtask

`ifdef ULPI_EXT_REG_EN
  task automatic test_ext_addr();
    req = 1; we = 1; addr = 'h81; wdata = 8'h6E;
    tick(); req = 0;
    total++; if (link_data !== 8'hAF) begin bad++; $display("FAIL ext_txcmd got=%h exp=af", link_data); end
    tick(); nxt = 1;
    tick();
    total++; if (link_data !== 8'h81) begin bad++; $display("FAIL ext_addr got=%h exp=81", link_data); end
    tick();
    total++; if (link_data !== 8'h6E) begin bad++; $display("FAIL ext_data got=%h exp=6e", link_data); end
    tick(); nxt = 0;
    total++; if (stp !== 1'b1) begin bad++; $display("FAIL ext_stp got=%b exp=1", stp); end
    tick();
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL ext_ack got=%b exp=1", ack); end
  endtask
`else
  task automatic test_ext_addr();
    req = 1; we = 1; addr = 'h2F; wdata = 8'h6E;
    tick(); req = 0;
    total++; if (link_data !== 8'hAF) begin bad++; $display("FAIL a2f_txcmd got=%h exp=af", link_data); end
    tick(); nxt = 1;
    tick();
    total++; if (link_data !== 8'h6E) begin bad++; $display("FAIL a2f_data got=%h exp=6e", link_data); end
    tick(); nxt = 0;
    total++; if (stp !== 1'b1) begin bad++; $display("FAIL a2f_stp got=%b exp=1", stp); end
    tick();
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL a2f_ack got=%b exp=1", ack); end
  endtask
`endif

  task automatic test_reset_mid();
    req = 1; we = 1; addr = 'h05; wdata = 8'h77;
    tick(); req = 0;
    total++; if (link_data !== 8'h85) begin bad++; $display("FAIL mid_txcmd got=%h exp=85", link_data); end
    rst_n = 0;
    #1;
    total++; if (phy_rst_n !== 1'b0 || busy !== 1'b1 || link_data !== 8'h00) begin bad++; $display("FAIL mid_async got=%b/%b/%h exp=0/1/00", phy_rst_n, busy, link_data); end
    tick();
    rst_n = 1;
    wait_phy_reset("mid");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_rxcmd_burst();
    test_busy_ignore();
    test_ext_addr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
